// File: rtl/set_lattice_counter.sv
// set_lattice_counter: counts lattice points (1..GRID)^2 satisfying a set
// expression over NC circles. Job handshake: en (accepted while idle),
// busy while held/scanned, one-cycle valid strobe with the held candidate.
module set_lattice_counter #(
  parameter int unsigned GRID  = 8,
  parameter int unsigned CW    = 4,
  parameter int unsigned NC    = 3,
  parameter int unsigned LANES = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2*NC*CW-1:0]   central,
  input  logic [NC*CW-1:0]     radius,
  input  logic [1:0]           mode,
  input  logic [2**NC-1:0]     lut,
  output logic                 busy,
  output logic                 valid,
  output logic [CNT_W-1:0]     candidate
);

  localparam int unsigned SW     = 2*CW + 3;
  localparam int unsigned LAST_X = GRID - LANES + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                state;
  logic [2*NC*CW-1:0]    cen_q;
  logic [NC*CW-1:0]      rad_q;
  logic [1:0]            mode_q;
  logic [2**NC-1:0]      lut_q;
  logic [CW-1:0]         x_q;
  logic [CW-1:0]         y_q;
  logic [CNT_W-1:0]      acc;
  logic [CNT_W-1:0]      group_cnt;

  // Squared distance of (px,py) from (cx,cy) compared against r^2; the
  // difference is taken as a CW+1-bit signed value and squared by magnitude.
  function automatic logic in_circle(input logic [CW-1:0] px,
                                     input logic [CW-1:0] py,
                                     input logic [CW-1:0] cx,
                                     input logic [CW-1:0] cy,
                                     input logic [CW-1:0] r);
    logic signed [CW:0] dx;
    logic signed [CW:0] dy;
    logic [CW:0]        ax;
    logic [CW:0]        ay;
    logic [SW-1:0]      d2;
    logic [SW-1:0]      r2;
    dx = $signed({1'b0, px}) - $signed({1'b0, cx});
    dy = $signed({1'b0, py}) - $signed({1'b0, cy});
    ax = dx[CW] ? $unsigned(-dx) : $unsigned(dx);
    ay = dy[CW] ? $unsigned(-dy) : $unsigned(dy);
    d2 = SW'(ax) * SW'(ax) + SW'(ay) * SW'(ay);
    r2 = SW'(r) * SW'(r);
    return (d2 <= r2);
  endfunction

  // Set function applied to the membership vector.
  function automatic logic set_fn(input logic [1:0]       md,
                                  input logic [NC-1:0]    m,
                                  input logic [2**NC-1:0] tt);
    case (md)
      2'b00:   return m[0];
      2'b01:   return m[0] & m[1];
      2'b10:   return m[0] ^ m[1];
      default: return tt[m];
    endcase
  endfunction

  // Count of hits among the LANES points of the current group.
  always_comb begin : group_eval
    logic [NC-1:0] m;
    logic [CW-1:0] px;
    group_cnt = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      m  = '0;
      px = x_q + CW'(l);
      for (int unsigned k = 0; k < NC; k++) begin
        m[k] = in_circle(px, y_q,
                         cen_q[(2*NC-2*k)*CW-1   -: CW],
                         cen_q[(2*NC-2*k-1)*CW-1 -: CW],
                         rad_q[(NC-k)*CW-1       -: CW]);
      end
      group_cnt = group_cnt + CNT_W'(set_fn(mode_q, m, lut_q));
    end
  end

  // Job FSM: accept/latch, raster scan with accumulation, result publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      valid     <= 1'b0;
      candidate <= '0;
      acc       <= '0;
      x_q       <= CW'(1);
      y_q       <= CW'(1);
      cen_q     <= '0;
      rad_q     <= '0;
      mode_q    <= '0;
      lut_q     <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            cen_q  <= central;
            rad_q  <= radius;
            mode_q <= mode;
            lut_q  <= lut;
            acc    <= '0;
            x_q    <= CW'(1);
            y_q    <= CW'(1);
            busy   <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          acc <= acc + group_cnt;
          if (x_q == CW'(LAST_X)) begin
            x_q <= CW'(1);
            if (y_q == CW'(GRID)) state <= DONE;
            else                  y_q   <= y_q + CW'(1);
          end else begin
            x_q <= x_q + CW'(LANES);
          end
        end
        DONE: begin
          candidate <= acc;
          valid     <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_set_lattice_counter.sv
// Directed bench for set_lattice_counter: a default-parameter instance and a
// LANES=4 instance share the job inputs and reset, each with its own en.
module tb_set_lattice_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic [7:0]  lut;
  logic        busy_a, valid_a, busy_b, valid_b;
  logic [7:0]  cand_a, cand_b;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  set_lattice_counter dut_a (
    .clk(clk), .rst(rst), .en(en_a), .central(central), .radius(radius),
    .mode(mode), .lut(lut), .busy(busy_a), .valid(valid_a), .candidate(cand_a)
  );

  set_lattice_counter #(.GRID(8), .CW(4), .NC(3), .LANES(4), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .central(central), .radius(radius),
    .mode(mode), .lut(lut), .busy(busy_b), .valid(valid_b), .candidate(cand_b)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Raise en for one edge; called #1 after a posedge, returns #1 after the accept edge.
  task automatic accept(input bit which);
    if (which) en_b = 1'b1; else en_a = 1'b1;
    @(posedge clk); #1;
    en_a = 1'b0;
    en_b = 1'b0;
    check("busy_after_accept", which ? busy_b : busy_a, 1);
  endtask

  // Count edges until valid is seen (bounded), then check latency, count and busy.
  task automatic wait_valid(input bit which, input string tag,
                            input int unsigned exp_cnt, input int unsigned exp_lat);
    int unsigned n = 0;
    bit seen = 1'b0;
    while (!seen && n < 300) begin
      @(posedge clk); #1;
      n++;
      if ((which ? valid_b : valid_a) === 1'b1) seen = 1'b1;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_count"}, which ? cand_b : cand_a, exp_cnt);
    check({tag, "_busy_low"}, which ? busy_b : busy_a, 0);
  endtask

  task automatic set_job(input logic [23:0] c, input logic [11:0] r,
                         input logic [1:0] md, input logic [7:0] tt);
    central = c;
    radius  = r;
    mode    = md;
    lut     = tt;
  endtask

  localparam logic [23:0] C_T1  = {4'd4, 4'd4, 4'd1, 4'd1, 4'd8, 4'd8};
  localparam logic [11:0] R_T1  = {4'd2, 4'd1, 4'd1};
  localparam logic [23:0] C_T2  = {4'd4, 4'd4, 4'd5, 4'd4, 4'd1, 4'd8};
  localparam logic [11:0] R_T2  = {4'd2, 4'd2, 4'd0};
  localparam logic [23:0] C_SAME = {4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
  localparam logic [11:0] R_SAME = {4'd2, 4'd2, 4'd2};

  initial begin
    int unsigned vcount;
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    set_job('0, '0, 2'b00, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_busy",  busy_a,  0);
    check("reset_valid", valid_a, 0);
    check("reset_cand",  cand_a,  0);
    check("reset_b_cand", cand_b, 0);

    // Test 1: single disc, mode 00
    set_job(C_T1, R_T1, 2'b00, 8'h00);
    accept(0);
    set_job('0, '0, 2'b11, 8'hFF);
    wait_valid(0, "t1", 13, 65);
    @(posedge clk); #1;
    check("t1_valid_drop", valid_a, 0);
    check("t1_cand_held", cand_a, 13);

    // Test 2: intersect then xor, second en during first valid cycle
    set_job(C_T2, R_T2, 2'b01, 8'h00);
    accept(0);
    wait_valid(0, "t2_and", 8, 65);
    set_job(C_T2, R_T2, 2'b10, 8'h00);
    accept(0);
    check("t2_valid_drop", valid_a, 0);
    wait_valid(0, "t2_xor", 10, 65);

    // Test 3: clipping and r=0 cases
    set_job({4'd1, 4'd1, 4'd8, 4'd8, 4'd8, 4'd8}, {4'd3, 4'd0, 4'd0}, 2'b00, 8'h00);
    accept(0);
    wait_valid(0, "t3_corner", 11, 65);
    set_job({4'd7, 4'd7, 4'd8, 4'd8, 4'd8, 4'd8}, {4'd0, 4'd0, 4'd0}, 2'b00, 8'h00);
    accept(0);
    wait_valid(0, "t3_r0", 1, 65);
    set_job({4'd0, 4'd0, 4'd8, 4'd8, 4'd8, 4'd8}, {4'd0, 4'd0, 4'd0}, 2'b00, 8'h00);
    accept(0);
    wait_valid(0, "t3_offboard", 0, 65);

    // Test 4: LUT mode with three coincident discs
    set_job(C_SAME, R_SAME, 2'b11, 8'h80);
    accept(0);
    wait_valid(0, "t4_lut80", 13, 65);
    set_job(C_SAME, R_SAME, 2'b11, 8'h01);
    accept(0);
    wait_valid(0, "t4_lut01", 51, 65);
    set_job(C_SAME, R_SAME, 2'b11, 8'hFF);
    accept(0);
    wait_valid(0, "t4_lutff", 64, 65);
    set_job(C_SAME, R_SAME, 2'b11, 8'h00);
    accept(0);
    wait_valid(0, "t4_lut00", 0, 65);

    // Test 5a: en during scan is ignored
    set_job(C_T1, R_T1, 2'b00, 8'h00);
    accept(0);
    repeat (10) begin @(posedge clk); #1; end
    set_job(C_SAME, R_SAME, 2'b11, 8'hFF);
    en_a = 1'b1;
    @(posedge clk); #1;
    en_a = 1'b0;
    wait_valid(0, "t5_ignore", 13, 54);

    // Test 5b: reset mid-scan aborts the job
    set_job(C_T2, R_T2, 2'b01, 8'h00);
    accept(0);
    repeat (30) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_rst_busy",  busy_a,  0);
    check("t5_rst_valid", valid_a, 0);
    check("t5_rst_cand",  cand_a,  0);
    vcount = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (valid_a === 1'b1) vcount++;
    end
    check("t5_no_valid_after_rst", vcount, 0);
    set_job({4'd1, 4'd1, 4'd8, 4'd8, 4'd8, 4'd8}, {4'd3, 4'd0, 4'd0}, 2'b00, 8'h00);
    accept(0);
    wait_valid(0, "t5_recover", 11, 65);

    // Test 6: four-lane instance
    set_job(C_T2, R_T2, 2'b01, 8'h00);
    accept(1);
    wait_valid(1, "t6_and", 8, 17);
    set_job(C_T2, R_T2, 2'b10, 8'h00);
    accept(1);
    wait_valid(1, "t6_xor", 10, 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
